fp_convert_pipe: RTL and testbench

//  Streaming, parametrised linear-to-float converter with a ready/valid handshake.

---
 rtl/fp_convert_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_fp_convert_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_convert_pipe.sv
// rtl/fp_convert_pipe.sv - three-stage elastic two's-complement to sign/exponent/significand converter
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active high; flushes every stage
//   in_data    two's-complement sample (IN_W bits)
//   in_round   0 = truncate, 1 = round-half-up; travels with its sample
//   in_valid   in_data/in_round valid
//   in_ready   converter accepts the input this cycle
//   out_sign   1 = sample was negative
//   out_exp    exponent (EXP_W bits)
//   out_sig    significand (SIG_W bits); value = out_sig << out_exp
//   out_sat    result was clamped
//   out_valid  out_* fields valid
//   out_ready  downstream accepts the output this cycle
module fp_convert_pipe #(
  parameter int IN_W  = 12,
  parameter int SIG_W = 4,
  parameter int EXP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_round,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [SIG_W-1:0] out_sig,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int MAG_W = IN_W - 1;
  localparam int EMAX  = MAG_W - SIG_W;
  localparam logic [EXP_W-1:0] EMAX_E = EXP_W'(EMAX);

  // Stage 1: sign / magnitude
  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q,  s1_sign_d;
  logic             s1_sat_q,   s1_sat_d;
  logic             s1_round_q, s1_round_d;
  logic [MAG_W-1:0] s1_mag_q,   s1_mag_d;

  // Stage 2: normalised exponent / significand / round bit
  logic             s2_valid_q, s2_valid_d;
  logic             s2_sign_q,  s2_sign_d;
  logic             s2_sat_q,   s2_sat_d;
  logic             s2_round_q, s2_round_d;
  logic             s2_rbit_q,  s2_rbit_d;
  logic [EXP_W-1:0] s2_exp_q,   s2_exp_d;
  logic [SIG_W-1:0] s2_sig_q,   s2_sig_d;

  // Stage 3: rounded result, drives the outputs directly
  logic             s3_valid_q, s3_valid_d;
  logic             s3_sign_q,  s3_sign_d;
  logic             s3_sat_q,   s3_sat_d;
  logic [EXP_W-1:0] s3_exp_q,   s3_exp_d;
  logic [SIG_W-1:0] s3_sig_q,   s3_sig_d;

  logic s1_load, s2_load, s3_load;

  logic [IN_W-1:0]  neg_data;
  int               lz_v;
  int               e_v;
  logic [SIG_W-1:0] norm_sig;
  logic             norm_rbit;
  logic [SIG_W:0]   inc_sig;
  logic [EXP_W-1:0] rnd_exp;
  logic [SIG_W-1:0] rnd_sig;
  logic             rnd_sat;

  // A stage loads when it is empty or when its contents move on this cycle.
  always_comb begin
    s3_load = !s3_valid_q || out_ready;
    s2_load = !s2_valid_q || s3_load;
    s1_load = !s1_valid_q || s2_load;
  end

  assign in_ready = !rst && s1_load;

  // S1: sign / magnitude
  always_comb begin
    neg_data   = -in_data;
    s1_valid_d = s1_load ? in_valid : s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_sat_d   = s1_sat_q;
    s1_round_d = s1_round_q;
    s1_mag_d   = s1_mag_q;
    if (s1_load && in_valid) begin
      s1_sign_d  = in_data[IN_W-1];
      s1_round_d = in_round;
      s1_sat_d   = 1'b0;
      if (!in_data[IN_W-1]) begin
        s1_mag_d = in_data[MAG_W-1:0];
      end else if (neg_data[IN_W-1]) begin
        // Only the most negative code negates back onto itself; clamp it.
        s1_mag_d = '1;
        s1_sat_d = 1'b1;
      end else begin
        s1_mag_d = neg_data[MAG_W-1:0];
      end
    end
  end

  // S2: normalise. The leading-zero count is capped at EMAX so small
  // magnitudes land at e=0 with the raw low bits as significand.
  always_comb begin
    lz_v = MAG_W;
    for (int i = 0; i < MAG_W; i++) begin
      if (s1_mag_q[i]) lz_v = MAG_W - 1 - i;
    end
    if (lz_v > EMAX) lz_v = EMAX;
    e_v = EMAX - lz_v;
    for (int k = 0; k < SIG_W; k++) begin
      norm_sig[k] = s1_mag_q[e_v + k];
    end
    if (e_v > 0) norm_rbit = s1_mag_q[e_v - 1];
    else         norm_rbit = 1'b0;

    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_sat_d   = s2_sat_q;
    s2_round_d = s2_round_q;
    s2_rbit_d  = s2_rbit_q;
    s2_exp_d   = s2_exp_q;
    s2_sig_d   = s2_sig_q;
    if (s2_load && s1_valid_q) begin
      s2_sign_d  = s1_sign_q;
      s2_sat_d   = s1_sat_q;
      s2_round_d = s1_round_q;
      s2_rbit_d  = norm_rbit;
      s2_exp_d   = EXP_W'(e_v);
      s2_sig_d   = norm_sig;
    end
  end

  // S3: round-half-up. A carry out of the significand renormalises to
  // 1000..0 one exponent higher, or saturates when already at EMAX.
  always_comb begin
    inc_sig = {1'b0, s2_sig_q} + (SIG_W+1)'(1);
    rnd_exp = s2_exp_q;
    rnd_sig = s2_sig_q;
    rnd_sat = 1'b0;
    if (s2_round_q && s2_rbit_q) begin
      if (!inc_sig[SIG_W]) begin
        rnd_sig = inc_sig[SIG_W-1:0];
      end else if (s2_exp_q < EMAX_E) begin
        rnd_exp = s2_exp_q + EXP_W'(1);
        rnd_sig = {1'b1, {(SIG_W-1){1'b0}}};
      end else begin
        rnd_exp = EMAX_E;
        rnd_sig = '1;
        rnd_sat = 1'b1;
      end
    end

    s3_valid_d = s3_load ? s2_valid_q : s3_valid_q;
    s3_sign_d  = s3_sign_q;
    s3_sat_d   = s3_sat_q;
    s3_exp_d   = s3_exp_q;
    s3_sig_d   = s3_sig_q;
    if (s3_load && s2_valid_q) begin
      s3_sign_d = s2_sign_q;
      s3_sat_d  = s2_sat_q | rnd_sat;
      s3_exp_d  = rnd_exp;
      s3_sig_d  = rnd_sig;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_sat_q   <= 1'b0;
      s1_round_q <= 1'b0;
      s1_mag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_sat_q   <= 1'b0;
      s2_round_q <= 1'b0;
      s2_rbit_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_sig_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_sign_q  <= 1'b0;
      s3_sat_q   <= 1'b0;
      s3_exp_q   <= '0;
      s3_sig_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_sat_q   <= s1_sat_d;
      s1_round_q <= s1_round_d;
      s1_mag_q   <= s1_mag_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_sat_q   <= s2_sat_d;
      s2_round_q <= s2_round_d;
      s2_rbit_q  <= s2_rbit_d;
      s2_exp_q   <= s2_exp_d;
      s2_sig_q   <= s2_sig_d;
      s3_valid_q <= s3_valid_d;
      s3_sign_q  <= s3_sign_d;
      s3_sat_q   <= s3_sat_d;
      s3_exp_q   <= s3_exp_d;
      s3_sig_q   <= s3_sig_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_sign  = s3_sign_q;
  assign out_exp   = s3_exp_q;
  assign out_sig   = s3_sig_q;
  assign out_sat   = s3_sat_q;

endmodule

// File: tb/tb_fp_convert_pipe.sv
// tb/tb_fp_convert_pipe.sv - bench for fp_convert_pipe (IN_W=12, SIG_W=4, EXP_W=3)
module tb_fp_convert_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] in_data;
  logic        in_round;
  logic        in_valid;
  logic        in_ready;
  logic        out_sign;
  logic [2:0]  out_exp;
  logic [3:0]  out_sig;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  logic [8:0]  exp_q[$];
  bit          hold_pending = 1'b0;
  logic [9:0]  hold_snap;
  int          accepted = 0;

  fp_convert_pipe #(.IN_W(12), .SIG_W(4), .EXP_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_round(in_round), .in_valid(in_valid), .in_ready(in_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig), .out_sat(out_sat),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] fields();
    return {out_sign, out_exp, out_sig, out_sat};
  endfunction

  // Reference: value = sig * 2**e, sig the top 4 significant bits of |x|.
  function automatic logic [8:0] model(input logic [11:0] d, input bit r);
    int  x, mag, p, e, sig, rbit;
    bit  sg, sat;
    x   = int'($signed(d));
    sg  = (x < 0);
    mag = sg ? -x : x;
    sat = 1'b0;
    if (mag > 2047) begin
      mag = 2047;
      sat = 1'b1;
    end
    p = -1;
    for (int t = mag; t > 0; t = t / 2) p++;
    e    = (p - 3 > 0) ? p - 3 : 0;
    sig  = mag / (1 << e);
    rbit = (e > 0) ? (mag / (1 << (e - 1))) % 2 : 0;
    if (r && rbit == 1) begin
      sig = sig + 1;
      if (sig == 16) begin
        if (e < 7) begin
          e   = e + 1;
          sig = 8;
        end else begin
          sig = 15;
          sat = 1'b1;
        end
      end
    end
    return {sg, 3'(e), 4'(sig), sat};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of scoreboarded traffic.
  task automatic step(input bit v, input logic [11:0] d, input bit r, input bit ordy);
    bit in_fire, out_fire;
    @(negedge clk);
    if (hold_pending) check("hold_stable", 32'({out_valid, fields()}), 32'(hold_snap));
    if (out_valid) begin
      if (exp_q.size() == 0) check("no_unexpected_out", 32'(out_valid), 32'(0));
      else                   check("stream_data", 32'(fields()), 32'(exp_q[0]));
    end
    in_valid  = v;
    in_data   = d;
    in_round  = r;
    out_ready = ordy;
    #1;
    in_fire      = in_valid && in_ready;
    out_fire     = out_valid && out_ready;
    hold_pending = out_valid && !out_ready;
    hold_snap    = {out_valid, fields()};
    @(posedge clk);
    if (out_fire && exp_q.size() > 0) void'(exp_q.pop_front());
    if (in_fire) begin
      exp_q.push_back(model(d, r));
      accepted++;
    end
  endtask

  // Single sample into an empty pipe; checks latency and the result fields.
  task automatic send_dir(input string tag, input logic [11:0] d, input bit r,
                          input logic [8:0] exp);
    int lat;
    int waits;
    @(negedge clk);
    in_data   = d;
    in_round  = r;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    waits = 0;
    #1;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check({tag, "_accept"}, 32'(in_ready), 32'(1));
    @(posedge clk);
    lat = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(3));
    check({tag, "_result"}, 32'(fields()), 32'(exp));
    @(posedge clk);
  endtask

  logic [11:0] stall_samples [5];
  logic [11:0] corner [6];

  initial begin
    rst = 1'b1; in_data = '0; in_round = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    stall_samples = '{12'd422, 12'd46, 12'hFD2, 12'd125, 12'd5};
    corner = '{12'd0, 12'h800, 12'h7FF, 12'h801, 12'd15, 12'd16};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_fields", 32'(fields()), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'(1));

    // Directed values
    send_dir("d422_r0", 12'd422, 1'b0, {1'b0, 3'd5, 4'd13, 1'b0});
    send_dir("d422_r1", 12'd422, 1'b1, {1'b0, 3'd5, 4'd13, 1'b0});
    send_dir("d5",      12'd5,   1'b0, {1'b0, 3'd0, 4'd5,  1'b0});
    send_dir("d0",      12'd0,   1'b1, {1'b0, 3'd0, 4'd0,  1'b0});
    send_dir("d46_r0",  12'd46,  1'b0, {1'b0, 3'd2, 4'd11, 1'b0});
    send_dir("d46_r1",  12'd46,  1'b1, {1'b0, 3'd2, 4'd12, 1'b0});
    send_dir("dm46_r1", 12'hFD2, 1'b1, {1'b1, 3'd2, 4'd12, 1'b0});
    send_dir("d125_r1", 12'd125, 1'b1, {1'b0, 3'd4, 4'd8,  1'b0});
    send_dir("d2047_r1",12'h7FF, 1'b1, {1'b0, 3'd7, 4'd15, 1'b1});
    send_dir("dm2048",  12'h800, 1'b0, {1'b1, 3'd7, 4'd15, 1'b1});

    // Backpressure: 5 samples offered while out_ready=0 for 6 cycles
    exp_q.delete();
    hold_pending = 1'b0;
    accepted = 0;
    for (int c = 0; c < 6; c++)
      step(accepted < 5, (accepted < 5) ? stall_samples[accepted] : 12'd0, c[0], 1'b0);
    check("stall_accepted", 32'(accepted), 32'(3));
    check("stall_in_ready", 32'(in_ready), 32'(0));
    for (int c = 0; c < 30 && (accepted < 5 || exp_q.size() > 0); c++)
      step(accepted < 5, (accepted < 5) ? stall_samples[accepted] : 12'd0, 1'b1, 1'b1);
    check("stall_all_accepted", 32'(accepted), 32'(5));
    check("stall_drained", 32'(exp_q.size()), 32'(0));

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      logic [11:0] d;
      d = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 5)] : 12'($urandom);
      step($urandom_range(0, 3) != 0, d, 1'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step(1'b0, 12'd0, 1'b0, 1'b1);
    check("random_drained", 32'(exp_q.size()), 32'(0));

    // Reset with 3 samples in flight
    for (int c = 0; c < 3; c++) step(1'b1, 12'(100 + c * 300), 1'b1, 1'b0);
    @(negedge clk);
    check("flight_full", 32'(out_valid), 32'(1));
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    check("rst_blocks_in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'(0));
    check("flush_fields", 32'(fields()), 32'(0));
    #1;
    check("flush_in_ready", 32'(in_ready), 32'(1));
    exp_q.delete();
    hold_pending = 1'b0;
    for (int c = 0; c < 5; c++) step(1'b0, 12'd0, 1'b0, 1'b1);
    send_dir("after_flush", 12'd46, 1'b1, {1'b0, 3'd2, 4'd12, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
